// File: rtl/filter_chan_sched.sv
// Purpose: shares one fixed-latency filter datapath stage among NUM_CH sample channels.
//   A round-robin arbiter issues the channel samples, and a tag pipeline routes each result back to its channel.
// Latency: ch_i_en at edge n -> dp_i_en after n+1 -> ch_o_en after n+2+DP_LATENCY (empty, uncontended channel).
// Backpressure: none. A sample that arrives at a full, ungranted channel is dropped and flagged in ovf_sticky.
//   ch_busy exposes holding-register occupancy. The datapath side never stalls.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   ch_i_en/ch_i_data       per-channel sample strobes and flattened samples (slice c = [c*W +: W])
//   ch_busy                 holding register of each channel is full
//   dp_i_en/dp_i            issue strobe and sample to the shared datapath
//   dp_o_en/dp_o            datapath result (dp_o_en is only checked, never trusted for routing)
//   ch_o_en/ch_o_data       per-channel result strobes and flattened results (slices hold between results)
//   ovf_sticky/ovf_clr      per-channel sample-dropped flags and their clear
//   dp_err                  sticky: a result was due but dp_o_en was low
module filter_chan_sched #(
  parameter int NUM_CH     = 4,
  parameter int width_H    = 5,
  parameter int width_W    = 20,
  parameter int DP_LATENCY = 1,
  localparam int W         = width_H + width_W,
  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     ch_i_en,
  input  logic [NUM_CH*W-1:0]   ch_i_data,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic                  dp_i_en,
  output logic [W-1:0]          dp_i,
  input  logic                  dp_o_en,
  input  logic [W-1:0]          dp_o,
  output logic [NUM_CH-1:0]     ch_o_en,
  output logic [NUM_CH*W-1:0]   ch_o_data,
  output logic [NUM_CH-1:0]     ovf_sticky,
  input  logic                  ovf_clr,
  output logic                  dp_err
);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [W-1:0]      hold [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [IDX_W-1:0]  ptr;

  logic              win_vld;
  logic [IDX_W-1:0]  win;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] ovf_set;

  // issue_tag rides alongside dp_i; tag_pipe then follows the datapath's own stages,
  // so the head tag is valid in the same cycle that dp_o carries that sample's result.
  tag_t issue_tag;
  tag_t tag_pipe [DP_LATENCY];
  tag_t head;

  assign ch_busy = full;
  assign head    = tag_pipe[DP_LATENCY-1];

  // First full channel at or after ptr, wrapping around.
  always_comb begin : arb_scan
    logic [IDX_W-1:0] cand;
    cand    = '0;
    win_vld = 1'b0;
    win     = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (!win_vld && full[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (win_vld) grant[win] = 1'b1;
    // A channel being granted on this edge frees its register, so a new sample is accepted.
    cap     = ch_i_en & (~full | grant);
    ovf_set = ch_i_en & full & ~grant;
  end

  // Holding registers, arbiter and issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) hold[c] <= '0;
      full       <= '0;
      ptr        <= '0;
      dp_i_en    <= 1'b0;
      dp_i       <= '0;
      issue_tag  <= '0;
      ovf_sticky <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cap[c]) begin
          hold[c] <= ch_i_data[c*W +: W];
          full[c] <= 1'b1;
        end else if (grant[c]) begin
          full[c] <= 1'b0;
        end
      end
      // A new overflow wins over a simultaneous clear.
      ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | ovf_set;
      dp_i_en    <= win_vld;
      issue_tag  <= '{vld: win_vld, idx: win};
      if (win_vld) begin
        dp_i <= hold[win];
        if (win == IDX_W'(NUM_CH - 1)) ptr <= '0;
        else                           ptr <= win + 1'b1;
      end
    end
  end

  // The tag pipeline shifts unconditionally, so the datapath must be strictly fixed-latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DP_LATENCY; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int s = 1; s < DP_LATENCY; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  // Result return. The tag alone decides routing; dp_o_en only feeds the consistency flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_o_en   <= '0;
      ch_o_data <= '0;
      dp_err    <= 1'b0;
    end else begin
      ch_o_en <= '0;
      if (head.vld) begin
        ch_o_en[head.idx]           <= 1'b1;
        ch_o_data[head.idx*W +: W]  <= dp_o;
        if (!dp_o_en) dp_err <= 1'b1;
      end
    end
  end

endmodule
